// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states
// and response error bit positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_MOD = 4'h1;
  localparam logic [3:0] OP_DIV = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h8;

  localparam int ERR_OVF = 0;
  localparam int ERR_DZ  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response handshakes between a requester and the ALU sequencer.
interface alu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_op;
  logic        cmd_use_acc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_r;
  logic [1:0]  rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_r, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_r, rsp_err
  );
endinterface

// File: rtl/alu_err_class.sv
// Classifies the ALU outcome into overflow / divide-by-zero flags.
// Unknown op codes never raise an error.
module alu_err_class
  import alu_seq_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [15:0] b,
  input  logic        alu_error,
  output logic [1:0]  err
);

  always_comb begin
    // NOTE: default every bit first so no path leaves err unassigned (no latch).
    err          = '0;
    err[ERR_OVF] = alu_error && (op == OP_ADD || op == OP_SUB);
    err[ERR_DZ]  = (op == OP_MOD || op == OP_DIV) && (b == '0);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command front end for the combinational 16-bit ALU: latches operands,
// holds them for a settle window, then captures result and error status.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [3:0]      alu_op,
  input  logic [31:0]     alu_r,
  input  logic            alu_error,
  output logic [31:0]     acc,
  output logic            err_sticky,
  input  logic            clr_sticky,
  output logic            busy
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        rsp_valid_q;
  logic [31:0] rsp_r_q;
  logic [1:0]  rsp_err_q;
  logic [1:0]  cap_err;

  alu_err_class u_err_class (
    .op        (alu_op),
    .b         (alu_b),
    .alu_error (alu_error),
    .err       (cap_err)
  );

  // Gated by rst so the requester never sees ready while reset is held.
  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_r     = rsp_r_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_err_q   <= '0;
      acc         <= '0;
      err_sticky  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the later capture-set below overrides this clear.
      if (clr_sticky) err_sticky <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            alu_a  <= bus.cmd_use_acc ? acc[15:0] : bus.cmd_a;
            alu_b  <= bus.cmd_b;
            alu_op <= bus.cmd_op;
            cnt    <= CNT_INIT;
            busy   <= 1'b1;
            state  <= DRIVE;
          end
        end

        DRIVE: begin
          if (cnt == '0) begin
            rsp_r_q     <= alu_r;
            rsp_err_q   <= cap_err;
            rsp_valid_q <= 1'b1;
            if (!cap_err[ERR_DZ]) acc <= alu_r;
            if (cap_err != '0) err_sticky <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: behavioural ALU, expected responses queued at issue
// and popped when the sequencer presents a response.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_error;
  logic [31:0] acc;
  logic        err_sticky;
  logic        clr_sticky;
  logic        busy;
  logic        err_inj;

  alu_sequencer_if bus ();

  alu_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_r      (alu_r),
    .alu_error  (alu_error),
    .acc        (acc),
    .err_sticky (err_sticky),
    .clr_sticky (clr_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
    case (op)
      4'h0:    return 32'(a) + 32'(b);
      4'h8:    return 32'(a) - 32'(b);
      4'h4:    return 32'(a) * 32'(b);
      4'h2:    return (b == 16'd0) ? 32'hFFFF_FFFF : 32'(a / b);
      4'h1:    return (b == 16'd0) ? 32'hFFFF_FFFF : 32'(a % b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_err(input logic [15:0] b, input logic [3:0] op,
                                         input logic inj);
    logic [1:0] e;
    e[0] = inj && (op == 4'h0 || op == 4'h8);
    e[1] = (op == 4'h1 || op == 4'h2) && (b == 16'd0);
    return e;
  endfunction

  always_comb begin
    alu_r     = ref_alu(alu_a, alu_b, alu_op);
    alu_error = err_inj;
  end

  typedef struct {
    logic [31:0] r;
    logic [1:0]  err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_acc    = '0;
  logic        m_sticky = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic use_acc, input logic inj, input int hold,
                        input logic clr_hold);
    logic [15:0] a_eff;
    exp_t        e;
    int          t0;
    bit          seen;
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    a_eff = use_acc ? m_acc[15:0] : a;
    e.r   = ref_alu(a_eff, b, op);
    e.err = ref_err(b, op, inj);
    exp_q.push_back(e);
    bus.cmd_valid   = 1'b1;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    bus.cmd_op      = op;
    bus.cmd_use_acc = use_acc;
    bus.rsp_ready   = (hold == 0);
    err_inj         = inj;
    clr_sticky      = clr_hold;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("busy", 32'(busy), 32'd1);
    check("alu_a", 32'(alu_a), 32'(a_eff));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_op", 32'(alu_op), 32'(op));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    if (!seen) begin
      check("rsp_timeout", 32'd0, 32'd1);
      err_inj    = 1'b0;
      clr_sticky = 1'b0;
      return;
    end
    check("latency", 32'(cyc - t0), 32'(S));
    check("rsp_r", bus.rsp_r, e.r);
    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
    if (!e.err[1]) m_acc = e.r;
    if (clr_hold) m_sticky = 1'b0;
    if (e.err != 2'b00) m_sticky = 1'b1;
    check("acc", acc, m_acc);
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    err_inj    = 1'b0;
    clr_sticky = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 16'h1234;
      bus.cmd_op    = OP_ADD;
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_r", bus.rsp_r, e.r);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("bp_alu_a", 32'(alu_a), 32'(a_eff));
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("ready_back", 32'(bus.cmd_ready), 32'd1);
    check("busy_clear", 32'(busy), 32'd0);
    check("rsp_r_hold", bus.rsp_r, e.r);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    m_sticky   = 1'b0;
    check("sticky_clr", 32'(err_sticky), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_a       = '0;
    bus.cmd_b       = '0;
    bus.cmd_op      = '0;
    bus.cmd_use_acc = 1'b0;
    bus.rsp_ready   = 1'b0;
    clr_sticky      = 1'b0;
    err_inj         = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_r", bus.rsp_r, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_acc", acc, 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_alu", {alu_a, alu_b}, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    do_cmd(16'd6, 16'd9, OP_ADD, 1'b0, 1'b0, 0, 1'b0);        // 15
    do_cmd(16'd0, 16'd3, OP_DIV, 1'b1, 1'b0, 0, 1'b0);        // acc 15 / 3 = 5
    do_cmd(16'd6, 16'd0, OP_DIV, 1'b0, 1'b0, 0, 1'b0);        // divide by zero, acc holds
    pulse_clr();
    do_cmd(16'h7FFF, 16'd1, OP_ADD, 1'b0, 1'b1, 0, 1'b0);     // overflow flagged
    pulse_clr();
    do_cmd(16'd3, 16'd4, OP_MUL, 1'b0, 1'b1, 0, 1'b0);        // alu_error ignored for MUL
    do_cmd(16'd5, 16'd9, OP_SUB, 1'b0, 1'b1, 0, 1'b0);        // SUB overflow flagged
    pulse_clr();
    do_cmd(16'd7, 16'd0, 4'h3, 1'b0, 1'b1, 0, 1'b0);          // unknown op: 0, no error
    do_cmd(16'd17, 16'd5, OP_MOD, 1'b0, 1'b0, 0, 1'b0);       // 2
    do_cmd(16'd17, 16'd0, OP_MOD, 1'b0, 1'b0, 0, 1'b1);       // set beats clear
    do_cmd(16'd6, 16'd9, OP_MUL, 1'b0, 1'b0, 5, 1'b0);        // backpressure
    do_cmd(16'd1, 16'd1, OP_ADD, 1'b1, 1'b0, 0, 1'b0);        // accepted right after

    // abort mid-operation; acc and sticky are non-zero going in
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 16'd1;
    bus.cmd_b     = 16'd2;
    bus.cmd_op    = OP_ADD;
    bus.cmd_use_acc = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_acc    = '0;
    m_sticky = 1'b0;
    #1;
    check("abort_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_acc", acc, m_acc);
    check("abort_sticky", 32'(err_sticky), 32'(m_sticky));
    check("abort_busy_clr", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    do_cmd(16'd2, 16'd3, OP_ADD, 1'b0, 1'b0, 0, 1'b0);        // back in service

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Synchronous command front end that sits directly upstream of the combinational 16-bit ALU breadboard (add/sub/mul/div/mod). It accepts one operation per valid/ready handshake, drives the ALU operand and op-code inputs and holds them stable for a fixed settle window. It then captures the 32-bit result and error status into a response register with its own valid/ready handshake. It also keeps a 32-bit accumulator that can replace operand A, and a sticky error flag.

## Interface
- SETTLE_CYCLES, default 2: number of cycles the operands are held on the ALU before capture; legal range 1..15.

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  16  operand A
- cmd_b  in  16  operand B
- cmd_op  in  4  ALU op code
- cmd_use_acc  in  1  when 1, operand A is acc[15:0] instead of cmd_a
- alu_a  out  16  to ALU inputA
- alu_b  out  16  to ALU inputB
- alu_op  out  4  to ALU op_code
- alu_r  in  32  from ALU R
- alu_error  in  1  from ALU error (adder overflow)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_r  out  32  captured result
- rsp_err  out  2  bit0 = overflow, bit1 = divide by zero
- acc  out  32  accumulator
- err_sticky  out  1  set by any non-zero rsp_err
- clr_sticky  in  1  clears err_sticky
- busy  out  1  state is not IDLE

## Operation
- Op codes: 0 ADD, 1 MOD, 2 DIV, 4 MUL, 8 SUB. All other codes are passed through unchanged. The ALU returns 0 for them, and they are never flagged as errors.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register the operands (A is selected by cmd_use_acc) and go to DRIVE with cnt=SETTLE_CYCLES-1.
  - DRIVE: the ALU outputs present the registered operands. When cnt==0, capture and go to RESP; otherwise decrement cnt.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE.
- Capture computes:
  - rsp_r = alu_r
  - rsp_err[0] = alu_error && (op==0 || op==8)
  - rsp_err[1] = (op==1 || op==2) && registered B==0
- Accumulator: acc <= alu_r on capture, unless rsp_err[1]=1, in which case acc holds.
- err_sticky: set on capture when rsp_err != 0. Cleared by clr_sticky. When a capture-set and clr_sticky occur in the same cycle, set wins.
- rsp_r and rsp_err hold their values until the next capture. They remain readable after rsp_valid falls.
- alu_a, alu_b and alu_op hold their last values in IDLE and RESP; they do not glitch back to zero.

## Timing
- Reset values:
  - state = IDLE
  - cmd_ready=0 while rst=1, and 1 in the first cycle after rst falls
  - rsp_valid=0, rsp_r=0, rsp_err=0, acc=0, err_sticky=0
  - alu_a=alu_b=0, alu_op=0, busy=0
- Latency: when a command is accepted at edge E0, rsp_valid rises after edge E0+SETTLE_CYCLES. Example: SETTLE_CYCLES=2, accept at edge 0, rsp_valid high after edge 2.
- There is no overlap between commands. cmd_ready returns the cycle after the rsp handshake. Minimum command spacing is SETTLE_CYCLES+2 cycles.
- cmd_use_acc samples acc at the accept edge. acc at that point already includes the previous capture.
- rst asserted in DRIVE or RESP aborts the transaction. No response is produced, and acc and err_sticky are cleared.
- The registered operands are not re-sampled while busy=1; cmd_* inputs are ignored.

## Structure
- Shared package alu_seq_pkg holds:
  - op-code constants OP_ADD=4'h0, OP_MOD=4'h1, OP_DIV=4'h2, OP_MUL=4'h4, OP_SUB=4'h8
  - the state enum (IDLE, DRIVE, RESP)
  - error bit indices ERR_OVF=0, ERR_DZ=1
- One natural sub-module: alu_err_class. It is combinational and maps (op, B, alu_error) to the 2-bit rsp_err.
- The FSM, counter, accumulator and sticky flag stay in alu_sequencer.

## Test plan
- Basic ADD: A=6, B=9, op=0, rsp_ready=1 → rsp_r=32'h0000000F, rsp_err=2'b00, acc=15, rsp_valid rises SETTLE_CYCLES edges after accept.
- Accumulator reuse: following the ADD, send cmd_use_acc=1, B=3, op=2 → alu_a=15, rsp_r=5, acc=5.
- Divide by zero: A=6, B=0, op=2 → rsp_r=32'hFFFFFFFF, rsp_err=2'b10, acc unchanged, err_sticky=1. Then pulse clr_sticky → err_sticky=0.
- Overflow: A=16'h7FFF, B=1, op=0 with alu_error=1 → rsp_err=2'b01, err_sticky=1. The same alu_error=1 with op=4 (MUL) → rsp_err=2'b00.
- Backpressure: MUL 6×9 with rsp_ready held low for 5 cycles → rsp_valid stays 1, rsp_r=32'h00000036 stable, cmd_ready=0 and a second cmd_valid is ignored. It is accepted one cycle after the rsp handshake.
- Reset mid-operation: assert rst during DRIVE → no rsp_valid. Next cycle after rst falls: cmd_ready=1, acc=0, err_sticky=0.
